operand_tf_input_assembler: RTL and testbench
=============================================

# operand_tf_input_assembler

Upstream feeder for the operand transformer. Collects a 5-beat stream (four element beats of 8 elements, then one scale/config beat) into a complete `operand_input_t` block of 32 elements, 16 micro-scales and `config_t`. Presents the block on a valid/ready port that connects directly to the transformer's `valid_in`/`ready_in`/`data_in`. A 2-slot ping-pong buffer lets the next block assemble while the transformer stalls on the current one.

## Interface
- `ELEMS_PER_BEAT`, 8: elements per element beat; fixed.
- `NUM_SLOTS`, 2: block buffer depth; fixed.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `valid_in` in 1: beat valid.
- `ready_in` out 1: beat accepted when `valid_in && ready_in`.
- `beat_elems` in 8*ELEM_WIDTH_IN: element payload; sampled on beats 0-3 only.
- `beat_scales` in 16*SCALE_WIDTH: micro-scales; sampled on beat 4 only.
- `beat_cfg` in `config_t`: block config; sampled on beat 4 only.
- `beat_last` in 1: marks the final beat of a block.
- `valid_out` out 1: a complete block is available.
- `ready_out` in 1: downstream accepts.
- `data_out` out `operand_input_t`: the head block.
- `err_framing` out 1: one-cycle pulse on a framing error.
- `occupancy` out 2: number of committed blocks, 0..2.

## Operation
- `beat_cnt` (0..4) indexes the block under assembly in slot `wr_ptr`.
- Accepted beat k, where k<4: write `elements[8k+j] = beat_elems[j]` for j=0..7.
- Accepted beat 4: write `micro_scales[0..15]` and `cfg`, then commit the slot.
  - Commit: `wr_ptr` toggles, `count++`, `beat_cnt` goes to 0.
- Framing is checked on every accepted beat:
  - `beat_last=1` on beat k<4 is an error.
  - `beat_last=0` on beat 4 is an error.
- On a framing error:
  - Discard the partial block; nothing is committed.
  - `beat_cnt` goes to 0, `err_framing` pulses next cycle, `wr_ptr` and `count` are unchanged.
  - The beat after the erroring beat is treated as beat 0.
- `ready_in = (count < 2)`, driven from registered state only; no combinational path from `ready_out`.
- `valid_out = (count > 0)`; `data_out` = slot[`rd_ptr`].
- Pop on `valid_out && ready_out`: `rd_ptr` toggles, `count--`.
- Simultaneous commit and pop: `count` is unchanged and both pointers toggle.
- `data_out` stays stable while `valid_out && !ready_out`.
- A slot is never overwritten while it is committed and not yet popped.

## Timing
- Reset values:
  - `ready_in=1`, `valid_out=0`, `err_framing=0`, `occupancy=0`.
  - `data_out` = all zeros; slot storage, pointers and `beat_cnt` are zeroed.
- Latency: `valid_out` rises on the edge that accepts beat 4, so it is visible the cycle after beat 4 handshakes.
- Throughput: one block per 5 accepted beats sustained, with zero bubbles when `ready_out` is held high.
- Full condition: with `count=2`, `ready_in` is 0.
  - Pop cycle: `ready_in` rises the cycle after the pop.
  - A beat presented during the pop cycle is not accepted.
- Reset mid-block: the partial block and all committed blocks are lost; outputs return to reset values immediately (asynchronous).
- `occupancy` equals `count` (registered).

## Structure
- Add to `operand_tf_pkg`:
  - `BEATS_PER_BLOCK=5`, `ELEMS_PER_BEAT=8`.
  - `typedef logic [$clog2(BEATS_PER_BLOCK)-1:0] beat_idx_t`.
- `operand_input_t`, `config_t`, `ELEM_WIDTH_IN` and `SCALE_WIDTH` are reused from the package unchanged.
- One sub-module, `operand_tf_slot_buf`:
  - 2-entry `operand_input_t` storage with field-granular write enables.
  - Ports: write pointer, read pointer, read data.
- Top level holds the beat counter, framing check, pointers and count.

## Test plan
- Single block, `ready_out=1`: beats with elements 0..31, scales 0x10..0x1F, `cfg.scale_sharing_mode=1` → `valid_out` high 1 cycle after beat 4; `data_out.elements[i]=i`, `micro_scales[i]=0x10+i`, `cfg` matches.
- Back-pressure: 3 blocks streamed, `ready_out=0` → `ready_in` falls after the 2nd commit, `occupancy=2`. Release `ready_out` → blocks emerge in order A, B, C with no data corruption.
- Framing error: `beat_last=1` on beat 2 → `err_framing` single pulse, `occupancy` stays 0. The following 5-beat block is delivered intact.
- Missing last: `beat_last=0` on beat 4 → error pulse, no commit. The next beat is taken as beat 0.
- Simultaneous commit and pop: `occupancy=1`, beat 4 accepted in the same cycle as the pop → `occupancy` stays 1, and the new block is at the head the next cycle.
- Async reset asserted after beat 2 with one block committed → `valid_out=0`, `ready_in=1`, `occupancy=0` immediately. A fresh block after reset is delivered correctly.

Source files
------------

// File: rtl/operand_tf_pkg.sv
// Shared types for the operand transformer and its input assembler.
// Widths, block layout and beat framing constants used throughout the slice.
package operand_tf_pkg;

    localparam int ELEM_WIDTH_IN   = 8;
    localparam int SCALE_WIDTH     = 8;
    localparam int NUM_ELEMS       = 32;
    localparam int NUM_SCALES      = 16;
    localparam int BEATS_PER_BLOCK = 5;
    localparam int ELEMS_PER_BEAT  = 8;
    localparam int ELEM_BEATS      = NUM_ELEMS / ELEMS_PER_BEAT;
    localparam int NUM_SLOTS       = 2;

    typedef logic [$clog2(BEATS_PER_BLOCK)-1:0] beat_idx_t;

    typedef struct packed {
        logic [1:0] scale_sharing_mode;
        logic [1:0] elem_format;
        logic [1:0] round_mode;
        logic       saturate;
        logic       bypass;
    } config_t;

    typedef logic [ELEMS_PER_BEAT-1:0][ELEM_WIDTH_IN-1:0] elem_beat_t;
    typedef logic [NUM_SCALES-1:0][SCALE_WIDTH-1:0]       scales_t;

    typedef struct packed {
        config_t                                   cfg;
        scales_t                                   micro_scales;
        logic [NUM_ELEMS-1:0][ELEM_WIDTH_IN-1:0]   elements;
    } operand_input_t;

    function automatic logic is_tail_beat(input beat_idx_t b);
        return b == beat_idx_t'(BEATS_PER_BLOCK - 1);
    endfunction

endpackage

// File: rtl/operand_tf_input_assembler_if.sv
// Beat-in / block-out handshake bundle between the beat source, the assembler and the transformer.
// Pure wiring: no latency; backpressure carried by ready_in / ready_out.
interface operand_tf_input_assembler_if;
    import operand_tf_pkg::*;

    logic           valid_in;
    logic           ready_in;
    elem_beat_t     beat_elems;
    scales_t        beat_scales;
    config_t        beat_cfg;
    logic           beat_last;
    logic           valid_out;
    logic           ready_out;
    operand_input_t data_out;
    logic           err_framing;
    logic [1:0]     occupancy;

    modport slave (
        input  valid_in, beat_elems, beat_scales, beat_cfg, beat_last, ready_out,
        output ready_in, valid_out, data_out, err_framing, occupancy
    );

    modport master (
        output valid_in, beat_elems, beat_scales, beat_cfg, beat_last, ready_out,
        input  ready_in, valid_out, data_out, err_framing, occupancy
    );

endinterface

// File: rtl/operand_tf_slot_buf.sv
// Two-entry block store with per-beat element write enables and a tail (scales+cfg) enable.
// Writes land on the clock edge; read port is combinational; no backpressure of its own.
module operand_tf_slot_buf
    import operand_tf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_ptr_i,
    input  logic [ELEM_BEATS-1:0] elem_we_i,
    input  logic                  tail_we_i,
    input  elem_beat_t            wr_elems_i,
    input  scales_t               wr_scales_i,
    input  config_t               wr_cfg_i,
    input  logic                  rd_ptr_i,
    output operand_input_t        rd_data_o
);

    operand_input_t slot_q [NUM_SLOTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                slot_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (wr_ptr_i == 1'(s)) begin
                    for (int k = 0; k < ELEM_BEATS; k++) begin
                        if (elem_we_i[k]) begin
                            slot_q[s].elements[k*ELEMS_PER_BEAT +: ELEMS_PER_BEAT] <= wr_elems_i;
                        end
                    end
                    if (tail_we_i) begin
                        slot_q[s].micro_scales <= wr_scales_i;
                        slot_q[s].cfg          <= wr_cfg_i;
                    end
                end
            end
        end
    end

    assign rd_data_o = slot_q[rd_ptr_i];

endmodule

// File: rtl/operand_tf_input_assembler.sv
// Assembles 5-beat streams into operand_input_t blocks in a ping-pong buffer; block valid 1 cycle after beat 4.
// ready_in depends only on registered occupancy (deasserts at 2 blocks); output holds while ready_out is low.
module operand_tf_input_assembler
    import operand_tf_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    operand_tf_input_assembler_if.slave   bus
);

    beat_idx_t             beat_cnt_q, beat_cnt_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  err_q, err_d;
    logic                  ready_in;
    logic                  accept;
    logic                  tail;
    logic                  frame_err;
    logic                  commit;
    logic                  pop;
    logic [ELEM_BEATS-1:0] elem_we;

    assign ready_in  = (count_q < 2'd2);
    assign accept    = bus.valid_in && ready_in;
    assign tail      = is_tail_beat(beat_cnt_q);
    // A tail beat must carry last, every earlier beat must not.
    assign frame_err = accept && (tail ? !bus.beat_last : bus.beat_last);
    assign commit    = accept && tail && bus.beat_last;
    assign pop       = (count_q != 2'd0) && bus.ready_out;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_d      = frame_err;
        elem_we    = '0;

        for (int k = 0; k < ELEM_BEATS; k++) begin
            elem_we[k] = accept && !bus.beat_last && (beat_cnt_q == beat_idx_t'(k));
        end

        if (accept) begin
            if (frame_err) begin
                beat_cnt_d = '0;
            end else if (tail) begin
                beat_cnt_d = '0;
                wr_ptr_d   = ~wr_ptr_q;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({commit, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            err_q      <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    operand_tf_slot_buf u_slot_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_ptr_i    (wr_ptr_q),
        .elem_we_i   (elem_we),
        .tail_we_i   (commit),
        .wr_elems_i  (bus.beat_elems),
        .wr_scales_i (bus.beat_scales),
        .wr_cfg_i    (bus.beat_cfg),
        .rd_ptr_i    (rd_ptr_q),
        .rd_data_o   (bus.data_out)
    );

    assign bus.ready_in    = ready_in;
    assign bus.valid_out   = (count_q != 2'd0);
    assign bus.err_framing = err_q;
    assign bus.occupancy   = count_q;

endmodule

// File: tb/tb_operand_tf_input_assembler.sv
// Directed bench for the input assembler: scoreboard of expected blocks popped by a handshake monitor.
module tb_operand_tf_input_assembler;
    import operand_tf_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    operand_tf_input_assembler_if bus();

    operand_tf_input_assembler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    operand_input_t sb[$];
    operand_input_t mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_blk(input string name, input operand_input_t act, input operand_input_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic operand_input_t mk_block(input int base, input logic [1:0] mode);
        operand_input_t b;
        b = '0;
        for (int i = 0; i < NUM_ELEMS; i++)  b.elements[i]     = 8'(base + i);
        for (int i = 0; i < NUM_SCALES; i++) b.micro_scales[i] = 8'(8'h10 + base + i);
        b.cfg.scale_sharing_mode = mode;
        b.cfg.elem_format        = 2'(base / 64);
        return b;
    endfunction

    // Monitor: every output handshake must match the oldest expected block.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.valid_out === 1'b1 && bus.ready_out === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_block: got %h expected none", bus.data_out);
            end else begin
                mon_exp = sb.pop_front();
                chk_blk("block_out", bus.data_out, mon_exp);
            end
        end
    end

    task automatic send_beat(input elem_beat_t e, input scales_t s, input config_t c, input logic last);
        int n;
        bus.beat_elems  = e;
        bus.beat_scales = s;
        bus.beat_cfg    = c;
        bus.beat_last   = last;
        bus.valid_in    = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.ready_in === 1'b1) break;
        end
        if (n == 200) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got ready_in=0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
    endtask

    // err_beat < 0 sends a well-formed block; otherwise flips beat_last on that beat and stops.
    task automatic send_block(input operand_input_t b, input int err_beat);
        logic last;
        for (int k = 0; k < BEATS_PER_BLOCK; k++) begin
            last = (k == BEATS_PER_BLOCK - 1);
            if (k == err_beat) last = !last;
            if (k == BEATS_PER_BLOCK - 1 && err_beat < 0) sb.push_back(b);
            send_beat(b.elements[k*ELEMS_PER_BEAT +: ELEMS_PER_BEAT], b.micro_scales, b.cfg, last);
            if (k == err_beat) return;
        end
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge clk);
        chk(name, sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    operand_input_t blk_a, blk_b, blk_c, blk_d, blk_e, blk_f, blk_g, blk_h;

    initial begin
        rst_n           = 1'b0;
        bus.valid_in    = 1'b0;
        bus.beat_elems  = '0;
        bus.beat_scales = '0;
        bus.beat_cfg    = '0;
        bus.beat_last   = 1'b0;
        bus.ready_out   = 1'b1;
        #1;
        chk("rst_ready_in", bus.ready_in, 1);
        chk("rst_valid_out", bus.valid_out, 0);
        chk("rst_err", bus.err_framing, 0);
        chk("rst_occ", bus.occupancy, 0);
        chk_blk("rst_data_out", bus.data_out, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single block: elements 0..31, scales 0x10..0x1F, sharing mode 1.
        blk_a = mk_block(0, 2'd1);
        send_block(blk_a, -1);
        chk("single_valid_out", bus.valid_out, 1);
        chk("single_occ", bus.occupancy, 1);
        wait_drain("single_drain");
        chk("single_occ_after", bus.occupancy, 0);

        // Back-pressure: two commits fill the buffer, third waits.
        bus.ready_out = 1'b0;
        blk_a = mk_block(8'h40, 2'd2);
        blk_b = mk_block(8'h60, 2'd3);
        blk_c = mk_block(8'h80, 2'd0);
        send_block(blk_a, -1);
        send_block(blk_b, -1);
        chk("full_occ", bus.occupancy, 2);
        chk("full_ready_in", bus.ready_in, 0);
        fork
            send_block(blk_c, -1);
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.ready_out = 1'b1;
                chk("pop_cycle_ready_in", bus.ready_in, 0);
                @(posedge clk);
                #1;
                chk("after_pop_ready_in", bus.ready_in, 1);
                chk("after_pop_occ", bus.occupancy, 1);
            end
        join
        wait_drain("bp_drain");

        // Framing error: last on beat 2.
        blk_d = mk_block(8'h20, 2'd1);
        send_block(blk_d, 2);
        chk("err2_pulse", bus.err_framing, 1);
        chk("err2_occ", bus.occupancy, 0);
        @(posedge clk);
        #1;
        chk("err2_pulse_end", bus.err_framing, 0);
        blk_d = mk_block(8'h30, 2'd2);
        send_block(blk_d, -1);
        wait_drain("err2_drain");

        // Missing last on beat 4.
        blk_d = mk_block(8'h50, 2'd3);
        send_block(blk_d, 4);
        chk("err4_pulse", bus.err_framing, 1);
        chk("err4_occ", bus.occupancy, 0);
        chk("err4_valid_out", bus.valid_out, 0);
        blk_d = mk_block(8'h70, 2'd0);
        send_block(blk_d, -1);
        wait_drain("err4_drain");

        // Commit and pop in the same cycle.
        bus.ready_out = 1'b0;
        blk_d = mk_block(8'h90, 2'd1);
        blk_e = mk_block(8'hA0, 2'd2);
        send_block(blk_d, -1);
        for (int k = 0; k < ELEM_BEATS; k++) begin
            send_beat(blk_e.elements[k*ELEMS_PER_BEAT +: ELEMS_PER_BEAT], '0, '0, 1'b0);
        end
        chk("simul_occ_before", bus.occupancy, 1);
        sb.push_back(blk_e);
        bus.beat_scales = blk_e.micro_scales;
        bus.beat_cfg    = blk_e.cfg;
        bus.beat_last   = 1'b1;
        bus.valid_in    = 1'b1;
        bus.ready_out   = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        chk("simul_occ_after", bus.occupancy, 1);
        chk("simul_valid_out", bus.valid_out, 1);
        chk_blk("simul_head", bus.data_out, blk_e);
        wait_drain("simul_drain");

        // Asynchronous reset with one block committed and one partial.
        bus.ready_out = 1'b0;
        blk_f = mk_block(8'hB0, 2'd3);
        blk_g = mk_block(8'hC0, 2'd0);
        send_block(blk_f, -1);
        for (int k = 0; k < 3; k++) begin
            send_beat(blk_g.elements[k*ELEMS_PER_BEAT +: ELEMS_PER_BEAT], '0, '0, 1'b0);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid_out", bus.valid_out, 0);
        chk("arst_ready_in", bus.ready_in, 1);
        chk("arst_occ", bus.occupancy, 0);
        chk_blk("arst_data_out", bus.data_out, '0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.ready_out = 1'b1;
        @(posedge clk);
        #1;
        blk_h = mk_block(8'hE0, 2'd1);
        send_block(blk_h, -1);
        wait_drain("arst_drain");
        chk("final_occ", bus.occupancy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
